// File: rtl/isl51002_mode_pkg.sv
// Shared types and constants for the ISL51002 mode-lock controller:
// mode encoding, config word selects, datapath widths and |a-b| helpers.
package isl51002_mode_pkg;

   localparam int VT_W  = 11;
   localparam int PC_W  = 20;
   localparam int CFG_W = 32;
   localparam int TO_W  = 22;

   typedef enum logic [1:0] {
      MODE_NO_SYNC = 2'd0,
      MODE_ACQUIRE = 2'd1,
      MODE_LOCKED  = 2'd2
   } mode_e;

   localparam logic [1:0] CFG_SEL_CONFIG  = 2'd0;
   localparam logic [1:0] CFG_SEL_CONFIG2 = 2'd1;
   localparam logic [1:0] CFG_SEL_CONFIG3 = 2'd2;

   // Unsigned distance, one bit wider than the operands.
   function automatic logic [VT_W:0] abs_diff_vt(input logic [VT_W-1:0] a, input logic [VT_W-1:0] b);
      return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
   endfunction

   function automatic logic [PC_W:0] abs_diff_pc(input logic [PC_W-1:0] a, input logic [PC_W-1:0] b);
      return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
   endfunction

endpackage

// File: rtl/isl51002_vs_edge.sv
// Vsync conditioning: polarity normalisation, 2-FF synchronizer and a
// single-cycle pulse on the falling edge of the synchronized signal.
module isl51002_vs_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic vsync,
   input  logic polarity,
   output logic vs_edge
);

   logic       norm;
   logic [2:0] sync_q;

   assign norm = vsync ^ ~polarity;

   // sync_q[1:0] is the synchronizer, sync_q[2] the previous synchronized value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[1:0], norm};
      end
   end

   assign vs_edge = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/isl51002_mode_ctrl.sv
// Mode-lock controller and config sequencer for the ISL51002 frontend.
// Define ISL51002_CFG_SHADOW_EN to double-buffer hv_in_config* to field boundaries.
module isl51002_mode_ctrl
   import isl51002_mode_pkg::*;
#(
   parameter int LOCK_FRAMES    = 3,
   parameter int UNLOCK_FRAMES  = 2,
   parameter int VTOTAL_TOL     = 1,
   parameter int PCNT_TOL_SHIFT = 8,
   parameter int TIMEOUT_CYCLES = 2700000
) (
   input  logic        CLK_MEAS_i,
   input  logic        reset_n,
   input  logic        VSYNC_i,
   input  logic        vsync_i_polarity,
   input  logic [10:0] vtotal,
   input  logic [19:0] pcnt_frame,
   input  logic        interlace_flag,
   input  logic [1:0]  cfg_sel,
   input  logic [31:0] cfg_wdata,
   input  logic        cfg_wr,
   input  logic        cfg_commit,
   output logic [31:0] hv_in_config,
   output logic [31:0] hv_in_config2,
   output logic [31:0] hv_in_config3,
   output logic        commit_pending,
   output logic        commit_done,
   output logic [1:0]  mode_state,
   output logic        mode_changed,
   output logic [10:0] locked_vtotal,
   output logic [19:0] locked_pcnt,
   output logic        locked_interlace
);

   localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_ONE      = TO_W'(1);
   localparam logic [3:0]      LOCK_LAST   = 4'(LOCK_FRAMES - 1);
   localparam logic [3:0]      UNLOCK_N    = 4'(UNLOCK_FRAMES);
   localparam logic [VT_W:0]   VT_TOL_L    = (VT_W + 1)'(VTOTAL_TOL);

   logic vs_edge;

   isl51002_vs_edge u_vs_edge (
      .clk      (CLK_MEAS_i),
      .rst_n    (reset_n),
      .vsync    (VSYNC_i),
      .polarity (vsync_i_polarity),
      .vs_edge  (vs_edge)
   );

   mode_e             state_q, state_d;
   logic [VT_W-1:0]   ref_vt_q, ref_vt_d;
   logic [PC_W-1:0]   ref_pc_q, ref_pc_d;
   logic              ref_il_q, ref_il_d;
   logic [3:0]        cnt_q, cnt_d, cnt_inc;
   logic [3:0]        miss_q, miss_d, miss_inc;
   logic [TO_W-1:0]   tcnt_q, tcnt_d;
   logic              mode_changed_d;
   logic [VT_W-1:0]   locked_vt_d;
   logic [PC_W-1:0]   locked_pc_d;
   logic              locked_il_d;
   logic [VT_W:0]     vt_diff;
   logic [PC_W:0]     pc_diff;
   logic [PC_W:0]     pc_tol;
   logic              sample_match;

   assign vt_diff      = abs_diff_vt(vtotal, ref_vt_q);
   assign pc_diff      = abs_diff_pc(pcnt_frame, ref_pc_q);
   assign pc_tol       = {1'b0, ref_pc_q >> PCNT_TOL_SHIFT};
   assign sample_match = (vt_diff <= VT_TOL_L) && (pc_diff <= pc_tol) &&
                         (interlace_flag == ref_il_q);
   assign cnt_inc      = cnt_q + 4'd1;
   assign miss_inc     = miss_q + 4'd1;

   always_ff @(posedge CLK_MEAS_i or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= MODE_NO_SYNC;
         ref_vt_q         <= '0;
         ref_pc_q         <= '0;
         ref_il_q         <= 1'b0;
         cnt_q            <= '0;
         miss_q           <= '0;
         tcnt_q           <= '0;
         mode_changed     <= 1'b0;
         locked_vtotal    <= '0;
         locked_pcnt      <= '0;
         locked_interlace <= 1'b0;
      end else begin
         state_q          <= state_d;
         ref_vt_q         <= ref_vt_d;
         ref_pc_q         <= ref_pc_d;
         ref_il_q         <= ref_il_d;
         cnt_q            <= cnt_d;
         miss_q           <= miss_d;
         tcnt_q           <= tcnt_d;
         mode_changed     <= mode_changed_d;
         locked_vtotal    <= locked_vt_d;
         locked_pcnt      <= locked_pc_d;
         locked_interlace <= locked_il_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      ref_vt_d       = ref_vt_q;
      ref_pc_d       = ref_pc_q;
      ref_il_d       = ref_il_q;
      cnt_d          = cnt_q;
      miss_d         = miss_q;
      mode_changed_d = 1'b0;
      locked_vt_d    = locked_vtotal;
      locked_pc_d    = locked_pcnt;
      locked_il_d    = locked_interlace;
      tcnt_d         = vs_edge ? '0 : ((tcnt_q == TO_LAST) ? tcnt_q : tcnt_q + TO_ONE);

      // A vsync edge always takes priority over the timeout.
      if (vs_edge) begin
         unique case (state_q)
            MODE_NO_SYNC: begin
               ref_vt_d = vtotal;
               ref_pc_d = pcnt_frame;
               ref_il_d = interlace_flag;
               cnt_d    = '0;
               state_d  = MODE_ACQUIRE;
            end
            MODE_ACQUIRE: begin
               if (sample_match) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc >= LOCK_LAST) begin
                     state_d        = MODE_LOCKED;
                     miss_d         = '0;
                     locked_vt_d    = ref_vt_q;
                     locked_pc_d    = ref_pc_q;
                     locked_il_d    = ref_il_q;
                     mode_changed_d = 1'b1;
                  end
               end else begin
                  ref_vt_d = vtotal;
                  ref_pc_d = pcnt_frame;
                  ref_il_d = interlace_flag;
                  cnt_d    = '0;
               end
            end
            MODE_LOCKED: begin
               if (sample_match) begin
                  miss_d = '0;
               end else if (miss_inc >= UNLOCK_N) begin
                  ref_vt_d       = vtotal;
                  ref_pc_d       = pcnt_frame;
                  ref_il_d       = interlace_flag;
                  cnt_d          = '0;
                  miss_d         = '0;
                  state_d        = MODE_ACQUIRE;
                  mode_changed_d = 1'b1;
               end else begin
                  miss_d = miss_inc;
               end
            end
            default: state_d = MODE_NO_SYNC;
         endcase
      end else if ((tcnt_q == TO_LAST) && (state_q != MODE_NO_SYNC)) begin
         state_d        = MODE_NO_SYNC;
         cnt_d          = '0;
         miss_d         = '0;
         mode_changed_d = (state_q == MODE_LOCKED);
      end
   end

   assign mode_state = state_q;

`ifdef ISL51002_CFG_SHADOW_EN
   logic [CFG_W-1:0] shadow0_q, shadow1_q, shadow2_q;
   logic             pending_q;
   logic             apply;

   // Without sync there are no field boundaries, so a pending commit applies at once.
   assign apply          = pending_q & (vs_edge | (state_q == MODE_NO_SYNC));
   assign commit_pending = pending_q;

   always_ff @(posedge CLK_MEAS_i or negedge reset_n) begin
      if (!reset_n) begin
         shadow0_q     <= '0;
         shadow1_q     <= '0;
         shadow2_q     <= '0;
         pending_q     <= 1'b0;
         commit_done   <= 1'b0;
         hv_in_config  <= '0;
         hv_in_config2 <= '0;
         hv_in_config3 <= '0;
      end else begin
         if (cfg_wr) begin
            case (cfg_sel)
               CFG_SEL_CONFIG:  shadow0_q <= cfg_wdata;
               CFG_SEL_CONFIG2: shadow1_q <= cfg_wdata;
               CFG_SEL_CONFIG3: shadow2_q <= cfg_wdata;
               default: ;
            endcase
         end
         // A commit landing on the applying edge stays pending for the next one.
         pending_q   <= cfg_commit | (pending_q & ~apply);
         commit_done <= apply;
         if (apply) begin
            hv_in_config  <= shadow0_q;
            hv_in_config2 <= shadow1_q;
            hv_in_config3 <= shadow2_q;
         end
      end
   end
`else
   assign commit_pending = 1'b0;

   always_ff @(posedge CLK_MEAS_i or negedge reset_n) begin
      if (!reset_n) begin
         commit_done   <= 1'b0;
         hv_in_config  <= '0;
         hv_in_config2 <= '0;
         hv_in_config3 <= '0;
      end else begin
         commit_done <= cfg_commit;
         if (cfg_wr) begin
            case (cfg_sel)
               CFG_SEL_CONFIG:  hv_in_config  <= cfg_wdata;
               CFG_SEL_CONFIG2: hv_in_config2 <= cfg_wdata;
               CFG_SEL_CONFIG3: hv_in_config3 <= cfg_wdata;
               default: ;
            endcase
         end
      end
   end
`endif

endmodule
